// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared FSM state encoding and frame constants for the 7-segment
//           serial transmitter.
// Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Controller states: wait, capture frame, shift 64 bits, pulse done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Eight digits of one byte each.
  localparam int FRAME_LEN = 64;

  // All segments off (active-low byte).
  localparam logic [7:0] BLANK = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/seg7_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_serial_tx_if
// Purpose : Request/data and serial-link signals of the 7-segment
//           transmitter. The master requests frames; the slave is the
//           transmitter and drives the shift-register link.
// Rev     : 1.0  initial release
// ============================================================================
interface seg7_serial_tx_if;
  logic        start;
  logic [31:0] disp_num;
  logic [7:0]  point;
  logic [7:0]  le;
  logic        seg_clk;
  logic        seg_dout;
  logic        seg_clrn;
  logic        seg_pen;
  logic        busy;
  logic        done;

  modport master (
    output start, disp_num, point, le,
    input  seg_clk, seg_dout, seg_clrn, seg_pen, busy, done
  );

  modport slave (
    input  start, disp_num, point, le,
    output seg_clk, seg_dout, seg_clrn, seg_pen, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/hex2seg7.sv
`default_nettype none
// ============================================================================
// Module  : hex2seg7
// Purpose : Combinational hex digit to segment byte decoder. Output byte is
//           {dp,g,f,e,d,c,b,a}, active-low.
// Rev     : 1.0  initial release
// ============================================================================
module hex2seg7 (
  input  logic [3:0] hex,
  input  logic       point,
  output logic [7:0] seg
);

  logic [6:0] seg_n;

  // Active-low glyph table for 0-9, A, b, C, d, E, F.
  always_comb begin
    seg_n = 7'h7F;
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

  assign seg = {~point, seg_n};

endmodule
`default_nettype wire

// File: rtl/seg7_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : seg7_serial_tx
// Purpose : Serialises eight hex digits (plus decimal points) into a 64-bit
//           frame for an external 7-segment shift-register chain, digit 7
//           first, each byte MSB first.
// Options : define SEG7_BLINK_EN to add the blink counter and per-digit
//           blanking driven by le.
// Rev     : 1.0  initial release
// ============================================================================
import seg7_pkg::*;

module seg7_serial_tx #(
  parameter int CLK_DIV    = 2,
  parameter int BLINK_BITS = 24
) (
  input  logic              clk,
  input  logic              rst,
  seg7_serial_tx_if.slave   bus
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t                 state;
  state_t                 state_next;
  logic [7:0]             div_cnt;
  logic                   half;      // 0: data phase (seg_clk low), 1: clock high
  logic [5:0]             bit_cnt;
  logic [FRAME_LEN-1:0]   frame;
  logic [FRAME_LEN-1:0]   frame_next;
  logic [7:0]             blank_mask;
  logic                   clrn;
  logic                   busy_c;
  logic                   done_c;
  logic                   pen_c;
  logic                   half_end;
  logic                   shift_end;

  assign half_end  = (div_cnt == DIV_LAST);
  assign shift_end = half_end && half && (bit_cnt == 6'd63);

`ifdef SEG7_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;

  // Free-running blink timebase; its MSB is the blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt + BLINK_BITS'(1);
  end

  assign blank_mask = bus.le & {8{~blink_cnt[BLINK_BITS-1]}};
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.le, BLINK_BITS[0]};
  assign blank_mask = '0;
`endif

  // One decoder per digit; digit 7 lands in the top byte so it leaves first.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_digit
      logic [7:0] seg_byte;
      hex2seg7 u_dec (
        .hex   (bus.disp_num[4*i+3:4*i]),
        .point (bus.point[i]),
        .seg   (seg_byte)
      );
      assign frame_next[8*i+7:8*i] = blank_mask[i] ? BLANK : seg_byte;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_next = state;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    pen_c      = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        pen_c  = 1'b1;
        if (bus.start) state_next = LOAD;
      end
      LOAD:  state_next = SHIFT;
      SHIFT: if (shift_end) state_next = LATCH;
      LATCH: begin
        done_c     = 1'b1;
        pen_c      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame capture and bit/half-period sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame   <= '0;
      div_cnt <= '0;
      half    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          frame   <= frame_next;
          div_cnt <= '0;
          half    <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            if (half) begin
              half    <= 1'b0;
              frame   <= {frame[FRAME_LEN-2:0], 1'b0};
              bit_cnt <= bit_cnt + 6'd1;
            end else begin
              half <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          div_cnt <= '0;
          half    <= 1'b0;
        end
      endcase
    end
  end

  // Shift-register clear is released on the first edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clrn <= 1'b0;
    else     clrn <= 1'b1;
  end

  assign bus.seg_clk  = (state == SHIFT) && half;
  assign bus.seg_dout = (state == SHIFT) && frame[FRAME_LEN-1];
  assign bus.seg_clrn = clrn;
  assign bus.seg_pen  = pen_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

endmodule
`default_nettype wire

// File: tb/tb_seg7_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_serial_tx
// Purpose : Self-checking bench for seg7_serial_tx: cycle-level reference
//           model plus directed frames with literal expected bytes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seg7_serial_tx;

  localparam int CLK_DIV    = 2;
  localparam int BLINK_BITS = 24;
  localparam int LATENCY    = 2 + 128 * CLK_DIV;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] LIT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  seg7_serial_tx_if bus ();

  seg7_serial_tx #(.CLK_DIV(CLK_DIV), .BLINK_BITS(BLINK_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame content from the display rules: digit 7 in the top byte.
  function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] p,
                                              input logic [7:0] l, input bit phase);
    logic [63:0] f;
    logic [3:0]  h;
    logic [7:0]  b;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      h = d[4*i +: 4];
      b = {~p[i], ~LIT[h]};
      if (BLINK_ON && l[i] && !phase) b = 8'hFF;
      f[8*i +: 8] = b;
    end
    return f;
  endfunction

  // Reference model: m_n counts edges since the start-sampling edge.
  bit          m_act   = 1'b0;
  int          m_n     = 0;
  longint      m_ticks = 0;
  logic [63:0] m_frame = '0;
  bit          m_clrn  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act   <= 1'b0;
      m_n     <= 0;
      m_ticks <= 0;
      m_clrn  <= 1'b0;
    end else begin
      m_clrn  <= 1'b1;
      m_ticks <= m_ticks + 1;
      if (m_act) begin
        if (m_n == 0)
          m_frame <= model_frame(bus.disp_num, bus.point, bus.le,
                                 ((m_ticks >> (BLINK_BITS - 1)) & 1) != 0);
        if (m_n == LATENCY - 1) m_act <= 1'b0;
        m_n <= m_n + 1;
      end else if (bus.start) begin
        m_act <= 1'b1;
        m_n   <= 0;
      end
    end
  end

  // Expected {busy,done,pen,seg_clk,seg_dout,clrn} for the current cycle.
  logic [5:0] exp_out;
  int         sm;
  always_comb begin
    exp_out = 6'b001000;
    sm      = 0;
    if (!rst && m_act) begin
      if (m_n == 0) begin
        exp_out = 6'b100000;
      end else if (m_n <= 128 * CLK_DIV) begin
        sm = m_n - 1;
        exp_out = {1'b1, 1'b0, 1'b0, (sm % (2 * CLK_DIV)) >= CLK_DIV,
                   m_frame[63 - sm / (2 * CLK_DIV)], 1'b0};
      end else begin
        exp_out = 6'b111000;
      end
    end
    exp_out[0] = !rst && m_clrn;
  end

  // Per-cycle compare plus a receiver that samples on seg_clk rising.
  logic [63:0] rx = '0;
  logic [63:0] last_rx = '0;
  int          rx_bits = 0;
  int          frames_rx = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    check("outputs", 64'({bus.busy, bus.done, bus.seg_pen, bus.seg_clk, bus.seg_dout, bus.seg_clrn}),
          64'(exp_out));
    if (bus.busy && !prev_busy) begin
      rx_bits <= 0;
    end else if (bus.seg_clk && !prev_sclk) begin
      rx      <= {rx[62:0], bus.seg_dout};
      rx_bits <= rx_bits + 1;
      if (rx_bits == 63) begin
        last_rx   <= {rx[62:0], bus.seg_dout};
        frames_rx <= frames_rx + 1;
      end
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    prev_sclk <= bus.seg_clk;
    prev_busy <= bus.busy;
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] p, input logic [7:0] l,
                      output int s_cyc);
    bus.disp_num = d;
    bus.point    = p;
    bus.le       = l;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    s_cyc = cyc;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s: busy still high after 400 cycles, expected idle", name);
    end
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp, input int frames_before,
                             input int dones_before, input int s_cyc);
    check({name, "_frames"}, 64'(frames_rx), 64'(frames_before + 1));
    check({name, "_dones"}, 64'(done_cnt), 64'(dones_before + 1));
    check({name, "_latency"}, 64'(done_cyc - s_cyc + 1), 64'(LATENCY));
    for (int i = 7; i >= 0; i--)
      check($sformatf("%s_byte%0d", name, i), 64'(last_rx[8*i +: 8]), 64'(exp[8*i +: 8]));
  endtask

  initial begin
    int s, fb, db;
    bus.start    = 1'b0;
    bus.disp_num = '0;
    bus.point    = '0;
    bus.le       = '0;

    // Reset state.
    tick(3);
    check("rst_clrn", 64'(bus.seg_clrn), 64'd0);
    check("rst_pen",  64'(bus.seg_pen),  64'd1);
    check("rst_busy", 64'(bus.busy),     64'd0);
    rst = 1'b0;
    tick(1);
    check("clrn_release", 64'(bus.seg_clrn), 64'd1);
    tick(2);

    // All zeros.
    fb = frames_rx; db = done_cnt;
    send(32'h0000_0000, 8'h00, 8'h00, s);
    wait_idle("zeros");
    check_frame("zeros", 64'hC0C0_C0C0_C0C0_C0C0, fb, db, s);
    tick(3);

    // Counting digits with digit-0 point.
    fb = frames_rx; db = done_cnt;
    send(32'h0123_4567, 8'h01, 8'h00, s);
    wait_idle("count");
    check_frame("count", 64'hC0F9_A4B0_9992_8278, fb, db, s);
    tick(3);

    // Blink enable on all digits while the blink phase is still 0.
    fb = frames_rx; db = done_cnt;
    send(32'h0123_4567, 8'h00, 8'hFF, s);
    wait_idle("blink");
    check_frame("blink", BLINK_ON ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hC0F9_A4B0_9992_82F8, fb, db, s);
    tick(3);

    // Second start mid-frame is ignored.
    fb = frames_rx; db = done_cnt;
    send(32'h89AB_CDEF, 8'hFF, 8'h00, s);
    tick(98);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_idle("restart");
    check_frame("restart", 64'h0010_0803_4621_060E, fb, db, s);
    tick(300);
    check("restart_one_done", 64'(done_cnt), 64'(db + 1));
    check("restart_busy_low", 64'(bus.busy), 64'd0);

    // Input change during SHIFT does not reach the frame in flight.
    fb = frames_rx; db = done_cnt;
    send(32'h7654_3210, 8'h00, 8'h00, s);
    tick(29);
    bus.disp_num = 32'hFFFF_FFFF;
    bus.point    = 8'hFF;
    wait_idle("hold");
    check_frame("hold", 64'hF882_9299_B0A4_F9C0, fb, db, s);
    tick(3);

    // Reset mid-frame aborts without done.
    db = done_cnt;
    send(32'h1111_1111, 8'h00, 8'h00, s);
    tick(48);
    rst = 1'b1;
    tick(1);
    check("abort_busy", 64'(bus.busy),    64'd0);
    check("abort_pen",  64'(bus.seg_pen), 64'd1);
    check("abort_sclk", 64'(bus.seg_clk), 64'd0);
    check("abort_done", 64'(bus.done),    64'd0);
    check("abort_clrn", 64'(bus.seg_clrn), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(300);
    check("abort_no_done", 64'(done_cnt), 64'(db));

    // Recovery frame after the abort.
    fb = frames_rx; db = done_cnt;
    send(32'h0000_0000, 8'h00, 8'h00, s);
    wait_idle("recover");
    check_frame("recover", 64'hC0C0_C0C0_C0C0_C0C0, fb, db, s);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seg7_serial_tx.md
SEG7_SERIAL_TX -- requirements
Module: seg7_serial_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per seg_clk half-period; legal range 1..255.
REQ-002 SHALL have parameter BLINK_BITS, default 24: width of the free-running blink counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request one frame transmission.
REQ-006 SHALL have port disp_num, input, 32: eight hex digits; digit i is disp_num[4i+3:4i].
REQ-007 SHALL have port point, input, 8: point[i]=1 lights the decimal point of digit i.
REQ-008 SHALL have port le, input, 8: le[i]=1 makes digit i blink.
REQ-009 SHALL have port seg_clk, output, 1: shift clock to the external shift-register chain.
REQ-010 SHALL have port seg_dout, output, 1: serial segment data.
REQ-011 SHALL have port seg_clrn, output, 1: active-low clear to the shift registers.
REQ-012 SHALL have port seg_pen, output, 1: display enable; 1 means the segments are lit.
REQ-013 SHALL have port busy, output, 1: frame in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at end of frame.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT and LATCH.
REQ-016 SHALL move IDLE->LOAD when start=1 at an IDLE edge; start in any other state is ignored and not queued.
REQ-017 SHALL, in LOAD (1 cycle), capture disp_num, point, le and the blink phase into a 64-bit frame register; later input changes SHALL NOT affect the frame in flight.
REQ-018 SHALL encode each segment byte as {dp,g,f,e,d,c,b,a}, active-low; dp bit = ~point[i].
REQ-019 SHALL force digit i's byte to 8'hFF when le[i]=1 and blink phase = 0; phase = MSB of the blink counter.
REQ-020 SHALL shift digit 7 first and digit 0 last, each byte MSB first: 64 bits total.
REQ-021 SHALL, for each bit in SHIFT, drive seg_dout with seg_clk=0 for CLK_DIV cycles, then hold seg_dout with seg_clk=1 for CLK_DIV cycles; the receiver samples on the rising edge.
REQ-022 SHALL hold seg_pen=0 from LOAD through SHIFT and return it to 1 in LATCH.
REQ-023 SHALL, in LATCH (1 cycle), assert done=1, then return to IDLE.
REQ-024 SHALL keep busy=1 in LOAD, SHIFT and LATCH, and busy=0 in IDLE.
REQ-025 SHALL assert done exactly 2+128*CLK_DIV cycles after the start-sampling edge (258 for CLK_DIV=2).
REQ-026 SHALL drive seg_clk=0 whenever not in SHIFT.
REQ-027 SHALL keep the blink counter running in all states and let it wrap modulo 2^BLINK_BITS.

Reset
REQ-028 SHALL, while rst=1, immediately force: IDLE, seg_clk=0, seg_dout=0, seg_clrn=0, seg_pen=1, busy=0, done=0, blink counter=0.
REQ-029 SHALL drive seg_clrn=1 from the first edge after rst deasserts.
REQ-030 SHALL abort a mid-frame reset without completing the frame or pulsing done.

Configuration
REQ-031 SHALL, when macro SEG7_BLINK_EN is defined, include the blink counter and the REQ-019 blanking.
REQ-032 SHALL, without SEG7_BLINK_EN, ignore le, omit the blink counter, and never blank a digit.

Structure
REQ-033 SHALL place the FSM state encoding, the frame length (64) and the segment constant BLANK=8'hFF in the shared package seg7_pkg.
REQ-034 SHALL implement hex-to-segment decoding in combinational sub-module hex2seg7 (4-bit hex plus point in, 8-bit byte out), instantiated 8 times.

Verification
REQ-035 Bench SHALL apply disp_num=32'h00000000, point=0, le=0, start pulse -> 64 sampled bits = eight bytes 8'hC0; done at cycle 258.
REQ-036 Bench SHALL apply disp_num=32'h01234567, point=8'h01 -> bytes C0,F9,A4,B0,99,92,82,78 (digit 7 first), with only the digit-0 byte changed to 8'h78.
REQ-037 Bench SHALL apply le=8'hFF, SEG7_BLINK_EN defined, blink phase 0 -> all bytes 8'hFF; repeat with SEG7_BLINK_EN undefined -> decoded digits.
REQ-038 Bench SHALL pulse start again at cycle 100 of a frame -> ignored; exactly one done pulse; busy low after LATCH.
REQ-039 Bench SHALL assert rst at cycle 50 of a frame -> next cycle shows IDLE, busy=0, seg_pen=1, seg_clk=0, and no done pulse.
REQ-040 Bench SHALL change disp_num during SHIFT -> shifted frame equals the value captured at LOAD.
